// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline stage registers: state encodings,
// the stage state type and the payload width of each stage boundary.
package pipe_pkg;

  typedef logic [1:0] pipe_state_t;

  localparam pipe_state_t PS_EMPTY = 2'd0;
  localparam pipe_state_t PS_ONE   = 2'd1;
  localparam pipe_state_t PS_FULL  = 2'd2;

  localparam int IFID_W  = 64;
  localparam int IDEX_W  = 147;
  localparam int EXMEM_W = 107;
  localparam int MEMWB_W = 71;

  // Entries held in a given state; the illegal code reports as empty.
  function automatic logic [1:0] ps_occ(input pipe_state_t s);
    case (s)
      PS_ONE:  ps_occ = 2'd1;
      PS_FULL: ps_occ = 2'd2;
      default: ps_occ = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle for one pipeline stage boundary: upstream side, downstream
// side, flush and the occupancy debug view.
interface pipe_skid_reg_if #(
  parameter int WIDTH = 32
);
  // A beat transfers on a side only when valid and ready are both high at the
  // rising edge; a source holding valid without ready keeps its data stable.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             flush;
  logic [1:0]       occupancy;

  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/pipe_data_reg.sv
// Payload register with load enable, synchronous clear to RESET_VAL and
// asynchronous active-low reset; holds its value when idle.
module pipe_data_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= RESET_VAL;
    end else if (i_clr) begin
      r_q <= RESET_VAL;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with a 2-entry skid buffer. The main register drives
// out_data; in_ready is registered so ready never chains across stages.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               CLR_DATA  = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  pipe_skid_reg_if.slave bus
);

  pipe_state_t      r_state;
  pipe_state_t      w_state_nxt;
  logic             r_in_ready;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_main_en;
  logic             w_skid_en;
  logic             w_main_from_skid;
  logic             w_clr;
  logic             w_out_valid;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_main_q;
  logic [WIDTH-1:0] w_skid_q;

  assign w_out_valid = (r_state == PS_ONE) || (r_state == PS_FULL);
  assign w_in_fire   = bus.in_valid & r_in_ready;
  assign w_out_fire  = w_out_valid & bus.out_ready;
  assign w_clr       = bus.flush & CLR_DATA;

  always_comb begin
    w_state_nxt      = r_state;
    w_main_en        = 1'b0;
    w_skid_en        = 1'b0;
    w_main_from_skid = 1'b0;
    if (bus.flush) begin
      // Flush wins over both handshakes; an accepted input that cycle is dropped.
      w_state_nxt = PS_EMPTY;
    end else begin
      case (r_state)
        PS_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = PS_ONE;
            w_main_en   = 1'b1;
          end
        end
        PS_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_main_en = 1'b1;
          end else if (w_in_fire) begin
            w_state_nxt = PS_FULL;
            w_skid_en   = 1'b1;
          end else if (w_out_fire) begin
            w_state_nxt = PS_EMPTY;
          end
        end
        PS_FULL: begin
          if (w_out_fire) begin
            w_state_nxt      = PS_ONE;
            w_main_en        = 1'b1;
            w_main_from_skid = 1'b1;
          end
        end
        default: w_state_nxt = PS_EMPTY;
      endcase
    end
  end

  assign w_main_d = w_main_from_skid ? w_skid_q : bus.in_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= PS_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != PS_FULL);
    end
  end

  pipe_data_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_main_en),
    .i_clr (w_clr),
    .i_d   (w_main_d),
    .o_q   (w_main_q)
  );

  pipe_data_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_skid_en),
    .i_clr (w_clr),
    .i_d   (bus.in_data),
    .o_q   (w_skid_q)
  );

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_main_q;
  assign bus.occupancy = ps_occ(r_state);

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios plus random traffic against a
// queue model; a second instance built with CLR_DATA=0 covers flush without clear.
module tb_pipe_skid_reg;

  logic clk;
  logic rst_n;

  int n_asserts = 0;
  int n_fail    = 0;

  // Reference model: the queue holds the payloads the stage should contain, head first.
  logic [31:0] mq[$];
  bit          m_ready;
  bit          m_cleared;

  pipe_skid_reg_if #(.WIDTH(32)) b1 ();
  pipe_skid_reg_if #(.WIDTH(32)) b2 ();

  pipe_skid_reg #(.WIDTH(32), .RESET_VAL(32'h0), .CLR_DATA(1'b1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1)
  );

  pipe_skid_reg #(.WIDTH(32), .RESET_VAL(32'h0), .CLR_DATA(1'b0)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("in_ready", {31'd0, b1.in_ready}, {31'd0, m_ready});
    chk("out_valid", {31'd0, b1.out_valid}, (mq.size() > 0) ? 32'd1 : 32'd0);
    chk("occupancy", {30'd0, b1.occupancy}, mq.size());
    chk("occ_not3", (b1.occupancy != 2'd3) ? 32'd1 : 32'd0, 32'd1);
    if (mq.size() > 0) chk("out_data", b1.out_data, mq[0]);
    else if (m_cleared) chk("out_data_clr", b1.out_data, 32'h0);
  endtask

  // One clock of dut1: drive, probe ready against the opposite out_ready, clock the model.
  task automatic cycle(input bit iv, input logic [31:0] id, input bit ordy, input bit fl);
    bit fire_in, fire_out;
    b1.in_valid  = iv;
    b1.in_data   = id;
    b1.flush     = fl;
    b1.out_ready = ~ordy;
    #1;
    chk("ready_vs_oready", {31'd0, b1.in_ready}, {31'd0, m_ready});
    b1.out_ready = ordy;
    #1;
    fire_in  = iv && m_ready;
    fire_out = (mq.size() > 0) && ordy;
    @(posedge clk);
    if (fl) begin
      mq.delete();
      m_cleared = 1'b1;
    end else begin
      if (fire_out) void'(mq.pop_front());
      if (fire_in) begin
        mq.push_back(id);
        m_cleared = 1'b0;
      end
    end
    m_ready = (mq.size() < 2);
    #1;
    check_model();
  endtask

  task automatic step2(input bit iv, input logic [31:0] id, input bit ordy, input bit fl);
    b2.in_valid  = iv;
    b2.in_data   = id;
    b2.out_ready = ordy;
    b2.flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    bit          iv;
    logic [31:0] id;
    bit          ordy, fl;

    rst_n = 1'b0;
    b1.in_valid = 1'b0; b1.in_data = '0; b1.out_ready = 1'b0; b1.flush = 1'b0;
    b2.in_valid = 1'b0; b2.in_data = '0; b2.out_ready = 1'b0; b2.flush = 1'b0;
    mq.delete();
    m_ready   = 1'b1;
    m_cleared = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_model();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Streaming: one value per cycle with one cycle of latency.
    for (int k = 1; k <= 8; k++) begin
      cycle(1'b1, k, 1'b1, 1'b0);
      chk("stream_data", b1.out_data, k);
      chk("stream_occ", {30'd0, b1.occupancy}, 32'd1);
    end
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("stream_drain", {31'd0, b1.out_valid}, 32'd0);

    // Backpressure: fill to FULL, then drain in order.
    cycle(1'b1, 32'hA, 1'b0, 1'b0);
    cycle(1'b1, 32'hB, 1'b0, 1'b0);
    chk("bp_full_ready", {31'd0, b1.in_ready}, 32'd0);
    chk("bp_full_head", b1.out_data, 32'hA);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("bp_second", b1.out_data, 32'hB);
    chk("bp_ready_back", {31'd0, b1.in_ready}, 32'd1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("bp_empty", {30'd0, b1.occupancy}, 32'd0);

    // Flush priority from FULL, then from ONE with a competing accept.
    cycle(1'b1, 32'hA, 1'b0, 1'b0);
    cycle(1'b1, 32'hB, 1'b0, 1'b0);
    cycle(1'b1, 32'hC, 1'b0, 1'b1);
    chk("fl_occ", {30'd0, b1.occupancy}, 32'd0);
    chk("fl_data_clr", b1.out_data, 32'h0);
    cycle(1'b1, 32'hE, 1'b1, 1'b0);
    cycle(1'b1, 32'hC, 1'b0, 1'b1);
    chk("fl_drop", {31'd0, b1.out_valid}, 32'd0);
    cycle(1'b1, 32'hC, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("fl_repeat", {30'd0, b1.occupancy}, 32'd0);

    // Asynchronous reset from FULL, seen before any edge.
    cycle(1'b1, 32'h11, 1'b0, 1'b0);
    cycle(1'b1, 32'h22, 1'b0, 1'b0);
    b1.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    mq.delete();
    m_ready   = 1'b1;
    m_cleared = 1'b1;
    chk("rst_out_valid", {31'd0, b1.out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, b1.in_ready}, 32'd1);
    chk("rst_occ", {30'd0, b1.occupancy}, 32'd0);
    chk("rst_data", b1.out_data, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b1, 32'h5, 1'b0, 1'b0);
    chk("rst_first_accept", b1.out_data, 32'h5);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // CLR_DATA=0 instance: flush clears valids but the payload stays.
    step2(1'b1, 32'hA, 1'b0, 1'b0);
    step2(1'b1, 32'hB, 1'b0, 1'b0);
    chk("nc_full", {30'd0, b2.occupancy}, 32'd2);
    step2(1'b1, 32'hC, 1'b0, 1'b1);
    chk("nc_occ", {30'd0, b2.occupancy}, 32'd0);
    chk("nc_valid", {31'd0, b2.out_valid}, 32'd0);
    chk("nc_keep", b2.out_data, 32'hA);
    step2(1'b1, 32'hD, 1'b0, 1'b0);
    chk("nc_push", b2.out_data, 32'hD);
    chk("nc_push_occ", {30'd0, b2.occupancy}, 32'd1);
    step2(1'b0, 32'h0, 1'b1, 1'b0);

    // Random traffic; a stalled input keeps its payload until accepted.
    iv = 1'b0;
    id = '0;
    for (int n = 0; n < 10000; n++) begin
      if (!(iv && !b1.in_ready)) begin
        iv = ($urandom_range(0, 3) != 0);
        id = $urandom;
      end
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 99) == 0);
      cycle(iv, id, ordy, fl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
